serial_mag_comp_ctrl: RTL and testbench
=======================================

# serial_mag_comp_ctrl

Bit-serial magnitude-comparison controller that time-shares a single external 1-bit comparator slice (outputs E/G/L) to compare two WIDTH-bit unsigned words. It walks the operands MSB-first and stops at the first unequal bit. It reports a registered one-hot greater/equal/less result with a start/done handshake. It sits between a requesting datapath and one comparator cell, replacing a WIDTH-wide parallel comparator where area matters more than latency.

## Interface
- WIDTH, 8, operand width in bits (≥1)
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled when busy=0
- a  input  WIDTH  operand A, unsigned, captured on accepted start
- b  input  WIDTH  operand B, unsigned, captured on accepted start
- cmp_a  output  1  current A bit driven to comparator slice
- cmp_b  output  1  current B bit driven to comparator slice
- cmp_g  input  1  slice result A>B (combinational from cmp_a/cmp_b)
- cmp_e  input  1  slice result A=B
- cmp_l  input  1  slice result A<B
- busy  output  1  high while comparing (RUN)
- done  output  1  one-cycle pulse, result valid
- gt, eq, lt  output  1 each  registered result, one-hot when err=0
- err  output  1  slice returned non-one-hot G/E/L

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0, operand registers and bit index 0.
- IDLE/DONE: start=1 → capture a, b into internal registers; bit index = WIDTH-1; clear gt/eq/lt/err; → RUN. start=0: IDLE stays IDLE, DONE → IDLE.
- RUN: cmp_a/cmp_b = captured bits at index. Each cycle, sample the slice outputs:
  - {g,e,l} not one-hot (none or more than one set) → err=1, gt/eq/lt=0 → DONE.
  - g=1 → gt=1 → DONE. l=1 → lt=1 → DONE (early termination).
  - e=1 and index=0 → eq=1 → DONE.
  - e=1 and index>0 → index-1, stay RUN.
- start while RUN: ignored. a/b changes after capture have no effect.
- cmp_a/cmp_b = 0 outside RUN.
- gt/eq/lt/err hold from DONE entry until the next accepted start or reset.
- done=1 only in DONE; busy=1 only in RUN.
- Index width is clog2(WIDTH), minimum 1. WIDTH=1 is legal: one RUN cycle.

## Timing
- start high in cycle 0 (accepted) → RUN from cycle 1. The bit at index WIDTH-k is examined in cycle k.
- The deciding bit examined in cycle k → done=1 and result valid in cycle k+1. Latency = k+1 cycles, best 2, worst WIDTH+1 (equal operands, or LSB decides).
- Results change only on the clock edge entering DONE, or are cleared on start acceptance. They are glitch-free registered outputs.
- Back-to-back: start=1 during the done cycle is accepted. The next RUN begins the following cycle and the results clear at that edge.
- The slice path is combinational within one cycle: cmp_a/cmp_b (from registers) → slice → cmp_g/e/l → next-state logic.
- rst asserted at any time, including mid-RUN: immediate return to IDLE, all outputs 0, no done pulse. Operation resumes only on a fresh start after rst deasserts.

## Test plan
- Bench instantiates the controller with a real 1-bit comparator slice on cmp_a/cmp_b/cmp_g/cmp_e/cmp_l, WIDTH=8.
- Equal operands: a=8'hA5, b=8'hA5, start in cycle 0 → busy cycles 1–8, done and eq=1 in cycle 9, gt=lt=err=0.
- MSB decides: a=8'h80, b=8'h7F → done, gt=1 in cycle 2. Then a=8'h12, b=8'h13 → LSB decides, lt=1 in cycle 9.
- Operand stability: start with a=8'h40, b=8'h3F. Change a to 8'h00 and pulse start during RUN → ignored, gt=1 in cycle 3, exactly one done pulse.
- Reset mid-run: start a=8'h01, b=8'h01, assert rst in cycle 4 → immediately busy=0, done=0, gt=eq=lt=0. A new start after release → eq=1 at cycle 9 relative to that start.
- Faulty slice: bench overrides the slice to force cmp_g=cmp_e=1 → err=1, gt=eq=lt=0, done in cycle 2.
- Back-to-back: start held high through the done cycle of a=8'hF0/b=8'h0F (gt) with new a=8'h0F/b=8'hF0 → second result lt=1, done 2 cycles after the first done.

Source files
------------

// File: rtl/serial_mag_comp_ctrl.sv
// Bit-serial unsigned magnitude comparator controller: walks A/B MSB-first through one
// external 1-bit G/E/L slice and stops at the first unequal bit.
module serial_mag_comp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cmp_a,
    output logic             cmp_b,
    input  logic             cmp_g,
    input  logic             cmp_e,
    input  logic             cmp_l,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             err
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx_q;
    logic             busy_q, done_q, gt_q, eq_q, lt_q, err_q;
    logic             slice_ok;

    assign slice_ok = ({cmp_g, cmp_e, cmp_l} == 3'b100) ||
                      ({cmp_g, cmp_e, cmp_l} == 3'b010) ||
                      ({cmp_g, cmp_e, cmp_l} == 3'b001);

    // Slice inputs come straight from registers and are forced low outside RUN.
    assign cmp_a = busy_q & a_q[idx_q];
    assign cmp_b = busy_q & b_q[idx_q];

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;
    assign err  = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        idx_q   <= IW'(WIDTH - 1);
                        gt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (!slice_ok || cmp_g || cmp_l || idx_q == '0) begin
                        err_q   <= !slice_ok;
                        gt_q    <= slice_ok & cmp_g;
                        lt_q    <= slice_ok & cmp_l;
                        eq_q    <= slice_ok & cmp_e;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Self-checking bench for serial_mag_comp_ctrl with a behavioural 1-bit slice (WIDTH=8).
module tb_serial_mag_comp_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cmp_a, cmp_b, cmp_g, cmp_e, cmp_l;
    logic         busy, done, gt, eq, lt, err;
    logic         force_bad = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 1-bit comparator slice; force_bad makes it report G and E together.
    assign cmp_g = force_bad ? 1'b1 : (cmp_a & ~cmp_b);
    assign cmp_e = force_bad ? 1'b1 : ~(cmp_a ^ cmp_b);
    assign cmp_l = force_bad ? 1'b0 : (~cmp_a & cmp_b);

    serial_mag_comp_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_g(cmp_g), .cmp_e(cmp_e), .cmp_l(cmp_l),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt), .err(err)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         gt, eq, lt;
        int           lat;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Launch one compare and wait for done. lat is the done cycle (start = cycle 0), -1 on timeout.
    task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                           output int lat, output int nbusy,
                           output logic rg, output logic re, output logic rl, output logic rerr);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; nbusy = 0; rg = 0; re = 0; rl = 0; rerr = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = c; rg = gt; re = eq; rl = lt; rerr = err;
                break;
            end
        end
    endtask

    // Reference: the highest differing bit h is examined in cycle W-h, so done lands one cycle later.
    function automatic int ref_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] x;
        int h;
        x = av ^ bv;
        h = 0;
        for (int i = 0; i < W; i++) if (x[i]) h = i;
        return W - h + 1;
    endfunction

    initial begin
        int lat, nb;
        logic rg, re, rl, rerr;
        int ndone;

        tbl[0] = '{8'hA5, 8'hA5, 0, 1, 0, 9};
        tbl[1] = '{8'h80, 8'h7F, 1, 0, 0, 2};
        tbl[2] = '{8'h12, 8'h13, 0, 0, 1, 9};
        tbl[3] = '{8'h00, 8'h00, 0, 1, 0, 9};
        tbl[4] = '{8'hFF, 8'h00, 1, 0, 0, 2};
        tbl[5] = '{8'h01, 8'h00, 1, 0, 0, 9};
        tbl[6] = '{8'h0F, 8'h10, 0, 0, 1, 5};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", {busy, done, gt, eq, lt, err, cmp_a, cmp_b}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {busy, done, gt, eq, lt, err}, 0);

        for (int i = 0; i < 7; i++) begin
            run_cmp(tbl[i].a, tbl[i].b, lat, nb, rg, re, rl, rerr);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_busy", i), nb, tbl[i].lat - 1);
            chk($sformatf("tbl%0d_res", i), {rg, re, rl, rerr}, {tbl[i].gt, tbl[i].eq, tbl[i].lt, 1'b0});
            @(negedge clk);
            chk($sformatf("tbl%0d_hold", i), {done, busy, gt, eq, lt}, {2'b00, tbl[i].gt, tbl[i].eq, tbl[i].lt});
        end

        // Randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (i % 5 == 0) ? ra ^ W'(1 << $urandom_range(W - 1)) : W'($urandom);
            if (i % 8 == 0) rb = ra;
            run_cmp(ra, rb, lat, nb, rg, re, rl, rerr);
            chk($sformatf("rnd%0d_lat", i), lat, ref_lat(ra, rb));
            chk($sformatf("rnd%0d_res", i), {rg, re, rl, rerr},
                {ra > rb, ra == rb, ra < rb, 1'b0});
        end

        // Operand stability: a changed and start re-pulsed during RUN have no effect
        @(negedge clk);
        a = 8'h40; b = 8'h3F; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0; lat = -1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) begin a = 8'h00; start = 1'b1; end
            if (c == 2) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = c; rg = gt; end
            end
        end
        chk("stab_lat", lat, 3);
        chk("stab_gt", rg, 1);
        chk("stab_ndone", ndone, 1);

        // Reset in the middle of RUN
        @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out", {busy, done, gt, eq, lt, err, cmp_a, cmp_b}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("midrst_idle%0d", c), {busy, done}, 0);
        end
        run_cmp(8'h01, 8'h01, lat, nb, rg, re, rl, rerr);
        chk("midrst_relat", lat, 9);
        chk("midrst_reeq", {rg, re, rl, rerr}, 4'b0100);

        // Faulty slice reports G and E together
        force_bad = 1'b1;
        run_cmp(8'h55, 8'h55, lat, nb, rg, re, rl, rerr);
        force_bad = 1'b0;
        chk("bad_lat", lat, 2);
        chk("bad_res", {rg, re, rl, rerr}, 4'b0001);

        // Back-to-back: start held through the first done cycle
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; start = 1'b1;
        @(posedge clk);
        #1 a = 8'h0F; b = 8'hF0;
        @(negedge clk);
        chk("b2b_c1", {busy, done}, 2'b10);
        @(negedge clk);
        chk("b2b_c2", {done, gt, eq, lt}, 4'b1100);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_c3", {busy, done, gt, eq, lt}, 5'b10000);
        @(negedge clk);
        chk("b2b_c4", {done, gt, eq, lt, err}, 5'b10010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
